// File: rtl/cc_miss_scheduler.sv
// Line-fill scheduler: pops one cache miss at a time and issues one AXI wrap burst per miss.
// FIFO non-empty to arvalid is 1 cycle; AR is held until arready, and pops stall at the outstanding limit.
module cc_miss_scheduler #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int BURST_BEATS     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_enable_i,
  input  logic [3:0]  cfg_max_outstanding_i,
  input  logic        err_clr_i,
  input  logic        miss_req_fifo_empty_i,
  input  logic [31:0] miss_req_fifo_rdata_i,
  output logic        miss_req_fifo_rden_o,
  output logic [3:0]  mem_arid_o,
  output logic [31:0] mem_araddr_o,
  output logic [3:0]  mem_arlen_o,
  output logic [2:0]  mem_arsize_o,
  output logic [1:0]  mem_arburst_o,
  output logic        mem_arvalid_o,
  input  logic        mem_arready_i,
  input  logic        mem_rvalid_i,
  input  logic        mem_rready_i,
  input  logic        mem_rlast_i,
  input  logic [1:0]  mem_rresp_i,
  output logic [3:0]  outstanding_o,
  output logic        busy_o,
  output logic        err_o
);
  localparam int            BW        = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_BEATS - 1);
  localparam logic [3:0]    MAX_LIM   = 4'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    lim;
  logic [BW-1:0] beat_cnt;
  logic          ar_hs, beat, stray, beat_ok, retire, err_set;

  assign mem_arid_o    = 4'h0;
  assign mem_arlen_o   = 4'(BURST_BEATS - 1);
  assign mem_arsize_o  = 3'b011;
  assign mem_arburst_o = 2'b10;

  // A programmed limit of zero would deadlock the fill path, so it behaves as one.
  always_comb begin
    lim = cfg_max_outstanding_i;
    if (cfg_max_outstanding_i == 4'd0)
      lim = 4'd1;
    else if (cfg_max_outstanding_i > MAX_LIM)
      lim = MAX_LIM;
  end

  always_comb begin
    state_nxt            = state;
    miss_req_fifo_rden_o = 1'b0;
    mem_arvalid_o        = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_enable_i && !miss_req_fifo_empty_i && (outstanding_o < lim)) begin
          miss_req_fifo_rden_o = 1'b1;
          state_nxt            = ISSUE;
        end
      end
      ISSUE: begin
        mem_arvalid_o = 1'b1;
        if (mem_arready_i)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ar_hs   = mem_arvalid_o && mem_arready_i;
  assign beat    = mem_rvalid_i && mem_rready_i;
  // A beat with nothing in flight is flagged and otherwise dropped, so the count never underflows.
  assign stray   = beat && (outstanding_o == 4'd0);
  assign beat_ok = beat && !stray;
  assign retire  = beat_ok && mem_rlast_i;
  assign err_set = stray ||
                   (beat_ok && ((mem_rresp_i != 2'b00) ||
                                (mem_rlast_i && (beat_cnt != LAST_BEAT)) ||
                                (!mem_rlast_i && (beat_cnt == LAST_BEAT))));

  assign busy_o = (state != IDLE) || (outstanding_o != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      mem_araddr_o  <= 32'h0;
      outstanding_o <= 4'd0;
      beat_cnt      <= '0;
      err_o         <= 1'b0;
    end else begin
      state <= state_nxt;
      // Critical word first: keep the requested 8-byte word, the wrap burst covers the line.
      if (miss_req_fifo_rden_o)
        mem_araddr_o <= miss_req_fifo_rdata_i & ~32'h7;
      if (ar_hs && !retire)
        outstanding_o <= outstanding_o + 4'd1;
      else if (retire && !ar_hs)
        outstanding_o <= outstanding_o - 4'd1;
      if (beat_ok)
        beat_cnt <= mem_rlast_i ? '0 : beat_cnt + 1'b1;
      if (err_set)
        err_o <= 1'b1;
      else if (err_clr_i)
        err_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cc_miss_scheduler.sv
// Bench for cc_miss_scheduler: directed scenarios then random traffic against a transaction-level model.
module tb_cc_miss_scheduler;
  localparam int MAXO  = 4;
  localparam int BEATS = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_enable_i;
  logic [3:0]  cfg_max_outstanding_i;
  logic        err_clr_i;
  logic        miss_req_fifo_empty_i;
  logic [31:0] miss_req_fifo_rdata_i;
  logic        miss_req_fifo_rden_o;
  logic [3:0]  mem_arid_o;
  logic [31:0] mem_araddr_o;
  logic [3:0]  mem_arlen_o;
  logic [2:0]  mem_arsize_o;
  logic [1:0]  mem_arburst_o;
  logic        mem_arvalid_o;
  logic        mem_arready_i;
  logic        mem_rvalid_i;
  logic        mem_rready_i;
  logic        mem_rlast_i;
  logic [1:0]  mem_rresp_i;
  logic [3:0]  outstanding_o;
  logic        busy_o;
  logic        err_o;

  cc_miss_scheduler #(.MAX_OUTSTANDING(MAXO), .BURST_BEATS(BEATS)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .cfg_enable_i          (cfg_enable_i),
    .cfg_max_outstanding_i (cfg_max_outstanding_i),
    .err_clr_i             (err_clr_i),
    .miss_req_fifo_empty_i (miss_req_fifo_empty_i),
    .miss_req_fifo_rdata_i (miss_req_fifo_rdata_i),
    .miss_req_fifo_rden_o  (miss_req_fifo_rden_o),
    .mem_arid_o            (mem_arid_o),
    .mem_araddr_o          (mem_araddr_o),
    .mem_arlen_o           (mem_arlen_o),
    .mem_arsize_o          (mem_arsize_o),
    .mem_arburst_o         (mem_arburst_o),
    .mem_arvalid_o         (mem_arvalid_o),
    .mem_arready_i         (mem_arready_i),
    .mem_rvalid_i          (mem_rvalid_i),
    .mem_rready_i          (mem_rready_i),
    .mem_rlast_i           (mem_rlast_i),
    .mem_rresp_i           (mem_rresp_i),
    .outstanding_o         (outstanding_o),
    .busy_o                (busy_o),
    .err_o                 (err_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
    end
  endtask

  function automatic int lim_of(input logic [3:0] c);
    if (c == 4'd0) return 1;
    if (int'(c) > MAXO) return MAXO;
    return int'(c);
  endfunction

  // Miss FIFO (owned by the stimulus process) and the reference model (owned by the checker).
  logic [31:0] fifo_q[$];
  logic        do_pop = 1'b0;
  int          m_out = 0, m_beats = 0, hs_cnt = 0;
  logic        m_err = 1'b0, m_pend = 1'b0;
  logic [31:0] m_addr = 32'h0, last_hs_addr = 32'h0;

  // Checks every cycle on the falling edge, then advances the model to the next rising edge.
  always @(negedge clk) begin
    logic exp_rden, beat, set, dec;
    if (!rst_n) begin
      expect_eq("rst_rden",    miss_req_fifo_rden_o, 0);
      expect_eq("rst_arvalid", mem_arvalid_o, 0);
      expect_eq("rst_araddr",  mem_araddr_o, 0);
      expect_eq("rst_out",     outstanding_o, 0);
      expect_eq("rst_err",     err_o, 0);
      expect_eq("rst_busy",    busy_o, 0);
      m_out = 0; m_beats = 0; m_err = 1'b0; m_pend = 1'b0; do_pop = 1'b0;
    end else begin
      exp_rden = !m_pend && cfg_enable_i && (fifo_q.size() != 0) &&
                 (m_out < lim_of(cfg_max_outstanding_i));
      expect_eq("rden",    miss_req_fifo_rden_o, exp_rden);
      expect_eq("arvalid", mem_arvalid_o, m_pend);
      expect_eq("out",     outstanding_o, m_out);
      expect_eq("err",     err_o, m_err);
      expect_eq("busy",    busy_o, m_pend || (m_out != 0));
      if (m_pend) begin
        expect_eq("araddr", mem_araddr_o, m_addr);
        expect_eq("ar_fields", {mem_arid_o, mem_arlen_o, mem_arsize_o, mem_arburst_o},
                  {4'h0, 4'h7, 3'b011, 2'b10});
      end
      if (mem_arvalid_o && mem_arready_i) begin
        hs_cnt++;
        last_hs_addr = mem_araddr_o;
      end
      do_pop = miss_req_fifo_rden_o;

      beat = mem_rvalid_i && mem_rready_i;
      set = 1'b0; dec = 1'b0;
      if (beat) begin
        if (m_out == 0) set = 1'b1;
        else begin
          if (mem_rresp_i != 2'b00) set = 1'b1;
          if (mem_rlast_i) begin
            if (m_beats != BEATS - 1) set = 1'b1;
            dec = 1'b1;
            m_beats = 0;
          end else begin
            if (m_beats == BEATS - 1) set = 1'b1;
            m_beats = (m_beats + 1) % BEATS;
          end
        end
      end
      m_out = m_out + ((m_pend && mem_arready_i) ? 1 : 0) - (dec ? 1 : 0);
      if (set) m_err = 1'b1;
      else if (err_clr_i) m_err = 1'b0;
      if (exp_rden) begin
        m_pend = 1'b1;
        m_addr = fifo_q[0] & ~32'h7;
      end else if (m_pend && mem_arready_i) m_pend = 1'b0;
    end
  end

  task automatic upd_fifo();
    miss_req_fifo_empty_i = (fifo_q.size() == 0);
    miss_req_fifo_rdata_i = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endtask

  task automatic push(input logic [31:0] a);
    fifo_q.push_back(a);
    upd_fifo();
  endtask

  // One clock: the FIFO pops a beat after the edge, new inputs go on 2 time units after it.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (do_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    upd_fifo();
    #1;
  endtask

  task automatic beats(input int n, input int last_at, input int bad_at, input logic ar_on_last);
    for (int i = 0; i < n; i++) begin
      mem_rvalid_i = 1'b1; mem_rready_i = 1'b1;
      mem_rlast_i  = (i == last_at);
      mem_rresp_i  = (i == bad_at) ? 2'b10 : 2'b00;
      if (ar_on_last && i == n - 1) mem_arready_i = 1'b1;
      cyc();
    end
    mem_rvalid_i = 1'b0; mem_rready_i = 1'b0; mem_rlast_i = 1'b0; mem_rresp_i = 2'b00;
  endtask

  task automatic rand_drive();
    cfg_enable_i  = ($urandom_range(9) != 0);
    if ($urandom_range(49) == 0) cfg_max_outstanding_i = 4'($urandom_range(15));
    err_clr_i     = ($urandom_range(24) == 0);
    mem_arready_i = ($urandom_range(2) != 0);
    if (fifo_q.size() < 6 && $urandom_range(2) == 0) push($urandom);
    mem_rready_i  = ($urandom_range(4) != 0);
    mem_rresp_i   = 2'b00;
    if (m_out != 0) begin
      mem_rvalid_i = 1'($urandom_range(1));
      mem_rlast_i  = (m_beats == BEATS - 1);
      if ($urandom_range(39) == 0) mem_rresp_i = 2'($urandom_range(3));
      if ($urandom_range(59) == 0) mem_rlast_i = !mem_rlast_i;
    end else begin
      mem_rvalid_i = ($urandom_range(79) == 0);
      mem_rlast_i  = 1'($urandom_range(1));
    end
  endtask

  initial begin
    int h0;
    rst_n = 1'b0; cfg_enable_i = 1'b0; cfg_max_outstanding_i = 4'd4; err_clr_i = 1'b0;
    mem_arready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rready_i = 1'b0;
    mem_rlast_i = 1'b0; mem_rresp_i = 2'b00;
    upd_fifo();
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // Single miss with a clean 8-beat fill.
    push(32'h0001_2345); cfg_enable_i = 1'b1; mem_arready_i = 1'b1;
    repeat (3) cyc();
    expect_eq("single_addr", last_hs_addr, 32'h0001_2340);
    expect_eq("single_out1", outstanding_o, 1);
    beats(8, 7, -1, 1'b0);
    expect_eq("single_out0", outstanding_o, 0);
    expect_eq("single_err",  err_o, 0);
    expect_eq("single_busy", busy_o, 0);

    // Software limit of 2 with four misses queued.
    cfg_max_outstanding_i = 4'd2; h0 = hs_cnt;
    for (int i = 0; i < 4; i++) push(32'h1000_0000 + 32'(i * 64 + i));
    repeat (10) cyc();
    expect_eq("lim_hs2",     32'(hs_cnt - h0), 2);
    expect_eq("lim_out",     outstanding_o, 2);
    expect_eq("lim_arvalid", mem_arvalid_o, 0);
    beats(8, 7, -1, 1'b0);
    repeat (2) cyc();
    expect_eq("lim_hs3", 32'(hs_cnt - h0), 3);
    repeat (3) begin beats(8, 7, -1, 1'b0); repeat (3) cyc(); end
    expect_eq("lim_hs4",  32'(hs_cnt - h0), 4);
    expect_eq("lim_done", outstanding_o, 0);
    cfg_max_outstanding_i = 4'd4;

    // AR backpressure: address held, no further pops.
    mem_arready_i = 1'b0; h0 = hs_cnt;
    push(32'hABCD_0017); push(32'hABCD_1237);
    repeat (6) cyc();
    expect_eq("bp_arvalid", mem_arvalid_o, 1);
    expect_eq("bp_araddr",  mem_araddr_o, 32'hABCD_0010);
    expect_eq("bp_rden",    miss_req_fifo_rden_o, 0);
    expect_eq("bp_out",     outstanding_o, 0);
    expect_eq("bp_hs",      32'(hs_cnt - h0), 0);
    mem_arready_i = 1'b1;
    repeat (4) cyc();
    expect_eq("bp_hs2",  32'(hs_cnt - h0), 2);
    expect_eq("bp_out2", outstanding_o, 2);
    repeat (2) beats(8, 7, -1, 1'b0);

    // AR handshake coincides with the retiring rlast beat.
    push(32'h0000_2008);
    repeat (3) cyc();
    mem_arready_i = 1'b0; push(32'h0000_3010);
    repeat (3) cyc();
    expect_eq("sim_arvalid", mem_arvalid_o, 1);
    expect_eq("sim_out_pre", outstanding_o, 1);
    beats(8, 7, -1, 1'b1);
    expect_eq("sim_out", outstanding_o, 1);
    beats(8, 7, -1, 1'b0);
    expect_eq("sim_out0", outstanding_o, 0);

    // Disable while an AR is waiting: it still completes, nothing further is popped.
    mem_arready_i = 1'b0;
    push(32'h0000_4000); push(32'h0000_5000); push(32'h0000_6000);
    cyc();
    expect_eq("dis_arvalid", mem_arvalid_o, 1);
    cfg_enable_i = 1'b0; mem_arready_i = 1'b1; h0 = hs_cnt;
    repeat (6) cyc();
    expect_eq("dis_hs",    32'(hs_cnt - h0), 1);
    expect_eq("dis_fifo",  32'(fifo_q.size()), 2);
    expect_eq("dis_out",   outstanding_o, 1);
    beats(8, 7, -1, 1'b0);

    // Error reporting.
    cfg_enable_i = 1'b1;
    repeat (6) cyc();
    expect_eq("err_out2", outstanding_o, 2);
    beats(8, 7, 2, 1'b0);
    expect_eq("err_resp", err_o, 1);
    repeat (3) cyc();
    expect_eq("err_sticky", err_o, 1);
    err_clr_i = 1'b1; cyc(); err_clr_i = 1'b0;
    expect_eq("err_clr", err_o, 0);
    beats(5, 4, -1, 1'b0);
    expect_eq("err_early_last", err_o, 1);
    expect_eq("err_out0", outstanding_o, 0);
    err_clr_i = 1'b1; cyc(); err_clr_i = 1'b0;
    beats(1, 0, -1, 1'b0);
    expect_eq("err_stray",     err_o, 1);
    expect_eq("err_stray_out", outstanding_o, 0);

    // Asynchronous reset in the middle of a fill.
    push(32'h0000_7777);
    repeat (3) cyc();
    mem_rvalid_i = 1'b1; mem_rready_i = 1'b1;
    repeat (3) cyc();
    cfg_enable_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    expect_eq("arst_out",     outstanding_o, 0);
    expect_eq("arst_err",     err_o, 0);
    expect_eq("arst_busy",    busy_o, 0);
    expect_eq("arst_arvalid", mem_arvalid_o, 0);
    expect_eq("arst_rden",    miss_req_fifo_rden_o, 0);
    expect_eq("arst_araddr",  mem_araddr_o, 0);
    mem_rvalid_i = 1'b0; mem_rready_i = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // Random traffic against the model.
    repeat (4000) begin
      rand_drive();
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/cc_miss_scheduler.md
Name: cc_miss_scheduler

Overview:
- Sequences cache-miss line fills between the miss-request FIFO and the memory AXI AR channel.
- Pops one miss address at a time, registers it, and issues one 8-beat wrap burst per miss.
- Tracks in-flight bursts against a configurable outstanding limit and retires each burst on its R-channel last beat.
- Flags protocol and response errors in a sticky register readable through the config block.

Parameters:
- MAX_OUTSTANDING, 4, hard upper bound on in-flight line-fill bursts (1..15).
- BURST_BEATS, 8, beats per line fill (64 B line / 8 B beat); drives the arlen value and the beat check.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- cfg_enable_i  input  1  1 = scheduler may issue new bursts
- cfg_max_outstanding_i  input  4  software outstanding limit
- err_clr_i  input  1  one-cycle pulse, clears err_o
- miss_req_fifo_empty_i  input  1  miss FIFO empty
- miss_req_fifo_rdata_i  input  32  miss FIFO head (show-ahead, valid while !empty)
- miss_req_fifo_rden_o  output  1  pop strobe
- mem_arid_o  output  4  constant 4'h0
- mem_araddr_o  output  32  registered burst address
- mem_arlen_o  output  4  BURST_BEATS-1 (4'h7)
- mem_arsize_o  output  3  3'b011
- mem_arburst_o  output  2  2'b10 (WRAP)
- mem_arvalid_o  output  1  AR valid
- mem_arready_i  input  1  AR ready
- mem_rvalid_i  input  1  R valid (monitored)
- mem_rready_i  input  1  R ready from the fill/reorder path (monitored)
- mem_rlast_i  input  1  R last
- mem_rresp_i  input  2  R response
- outstanding_o  output  4  bursts issued and not yet retired
- busy_o  output  1  (state != IDLE) or (outstanding_o != 0)
- err_o  output  1  sticky error

Behaviour:
- Interface: one clock clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - miss_req_fifo_rden_o=0, mem_arvalid_o=0, mem_araddr_o=0.
  - outstanding_o=0, err_o=0, busy_o=0, beat counter=0, FSM=IDLE.
- Effective limit:
  - lim = min(cfg_max_outstanding_i, MAX_OUTSTANDING).
  - cfg_max_outstanding_i=0 is treated as 1.
- FSM IDLE:
  - If cfg_enable_i and !miss_req_fifo_empty_i and outstanding_o < lim, then in that cycle:
    - assert miss_req_fifo_rden_o for exactly 1 cycle;
    - capture {rdata[31:3],3'b000} into mem_araddr_o (critical-word-first, 8 B aligned);
    - go to ISSUE.
  - Otherwise rden stays 0.
- FSM ISSUE:
  - mem_arvalid_o=1; mem_araddr_o is held stable until handshake.
  - On mem_arvalid_o && mem_arready_i: increment outstanding, drop arvalid, return to IDLE.
  - Minimum spacing between AR handshakes is 2 cycles; latency from a non-empty FIFO to arvalid is 1 cycle.
- Disable: deasserting cfg_enable_i blocks new pops only. A burst already in ISSUE completes its handshake, and in-flight bursts retire normally.
- Retire:
  - Each beat (mem_rvalid_i && mem_rready_i) increments a 3-bit beat counter.
  - A beat with mem_rlast_i=1 decrements outstanding and clears the beat counter.
- Simultaneous AR handshake and retire in the same cycle: outstanding unchanged.
- err_o set (sticky) on any of:
  - a beat with mem_rresp_i != 2'b00;
  - rlast on a beat other than beat BURST_BEATS-1;
  - beat BURST_BEATS-1 without rlast;
  - a beat while outstanding_o == 0. In this case outstanding stays at 0 (no underflow) and the beat is otherwise ignored.
- err_clr_i clears err_o. If a set condition occurs in the same cycle as err_clr_i, set wins.
- outstanding never exceeds lim. If software lowers the limit below the current count, no new issue occurs until the count falls below the new limit.
- The FIFO is never popped when empty, including when empty_i and the pop condition occur in the same cycle.

Test Plan:
- Single miss: FIFO head 0x0001_2345, enable=1, arready=1 one cycle after arvalid -> rden 1 cycle; araddr=0x0001_2340, arlen=7, arburst=2'b10; outstanding goes 0->1; 8 beats with rlast on beat 8 -> outstanding=0, err_o=0, busy_o=0.
- Limit: cfg_max=2, 4 misses queued, no R beats -> exactly 2 AR handshakes, then arvalid stays 0 and outstanding=2. Retire one burst -> third AR issues within 2 cycles.
- AR backpressure: arready held 0 for 5 cycles -> arvalid stays 1, araddr is stable, no further rden, and outstanding increments only on the handshake cycle.
- Simultaneous events: AR handshake in the same cycle as an rlast beat with outstanding=1 -> outstanding stays 1.
- Errors:
  - rresp=2'b10 on beat 3 -> err_o=1 and stays 1; err_clr_i pulse -> err_o=0.
  - rlast on beat 5 -> err_o=1.
  - a stray beat at outstanding=0 -> err_o=1 and outstanding stays 0.
- Reset/disable:
  - cfg_enable_i dropped while in ISSUE -> the AR still completes, then no further pops.
  - rst_n asserted mid-burst -> all outputs go to reset values immediately, asynchronously.
